regfile_port_sched: RTL and testbench

REGFILE_PORT_SCHED -- requirements
Module: regfile_port_sched

---
 rtl/regfile_sched_pkg.sv | 9 +
 rtl/wr_fifo.sv | 53 +++++
 rtl/regfile_port_sched.sv | 90 +++++++++
 tb/tb_regfile_port_sched.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/regfile_sched_pkg.sv
// regfile_sched_pkg: shared widths and the pending-write entry type
package regfile_sched_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wr_entry_t;
endpackage

// File: rtl/wr_fifo.sv
// wr_fifo: push-2/pop-1 synchronous FIFO exposing every slot for hazard compare
module wr_fifo
    import regfile_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push0,
    input  wr_entry_t                  i_data0,
    input  logic                       i_push1,
    input  wr_entry_t                  i_data1,
    input  logic                       i_pop,
    output wr_entry_t                  o_head,
    output logic [$clog2(DEPTH):0]     o_count,
    output wr_entry_t [DEPTH-1:0]      o_entries,
    output logic [DEPTH-1:0]           o_valid
);
    localparam int AW = $clog2(DEPTH);
    wr_entry_t [DEPTH-1:0] r_mem;
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;
    // Pointers wrap naturally because DEPTH is a power of two; the caller never exceeds free space.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(i_push0) + AW'(i_push1);
            r_rd_ptr <= r_rd_ptr + AW'(i_pop);
            r_count  <= r_count + (AW+1)'(i_push0) + (AW+1)'(i_push1) - (AW+1)'(i_pop);
        end
    end
    // Storage: when both push, wr0 lands first; a lone push takes the first free slot.
    always_ff @(posedge clk) begin
        if (!reset && i_push0 && i_push1) begin
            r_mem[r_wr_ptr]          <= i_data0;
            r_mem[r_wr_ptr + AW'(1)] <= i_data1;
        end else if (!reset && (i_push0 || i_push1)) begin
            r_mem[r_wr_ptr] <= i_push0 ? i_data0 : i_data1;
        end
    end
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_entries = r_mem;
    for (genvar i = 0; i < DEPTH; i++) begin : g_valid
        logic [AW-1:0] w_off;
        assign w_off      = AW'(i) - r_rd_ptr;
        assign o_valid[i] = {1'b0, w_off} < r_count;
    end
endmodule

// File: rtl/regfile_port_sched.sv
// regfile_port_sched: arbitrates two writeback clients into one register-file write port
module regfile_port_sched
    import regfile_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr0_valid,
    output logic                    wr0_ready,
    input  logic [REG_ADDR_W-1:0]   wr0_addr,
    input  logic [DATA_W-1:0]       wr0_data,
    input  logic                    wr1_valid,
    output logic                    wr1_ready,
    input  logic [REG_ADDR_W-1:0]   wr1_addr,
    input  logic [DATA_W-1:0]       wr1_data,
    input  logic [REG_ADDR_W-1:0]   rd_addr_a,
    input  logic [REG_ADDR_W-1:0]   rd_addr_b,
    output logic                    hazard_a,
    output logic                    hazard_b,
    output logic                    RegWrite,
    output logic [REG_ADDR_W-1:0]   writeReg,
    output logic [DATA_W-1:0]       writeData,
    output logic [$clog2(DEPTH):0]  occupancy
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic                  r_rr;
    logic [CW-1:0]         w_free;
    logic                  w_push0;
    logic                  w_push1;
    logic                  w_pop;
    wr_entry_t             w_head;
    wr_entry_t [DEPTH-1:0] w_entries;
    logic [DEPTH-1:0]      w_valid;

    // Free space comes from registered occupancy only, so a same-cycle pop never helps.
    assign w_free    = CW'(DEPTH) - occupancy;
    assign wr0_ready = !reset && (w_free >= CW'(2) || (w_free == CW'(1) && !r_rr));
    assign wr1_ready = !reset && (w_free >= CW'(2) || (w_free == CW'(1) && r_rr));
    assign w_push0   = wr0_valid && wr0_ready && wr0_addr != '0;
    assign w_push1   = wr1_valid && wr1_ready && wr1_addr != '0;
    assign w_pop     = occupancy != '0;

    wr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .i_push0  (w_push0),
        .i_data0  ('{addr: wr0_addr, data: wr0_data}),
        .i_push1  (w_push1),
        .i_data1  ('{addr: wr1_addr, data: wr1_data}),
        .i_pop    (w_pop),
        .o_head   (w_head),
        .o_count  (occupancy),
        .o_entries(w_entries),
        .o_valid  (w_valid)
    );

    // Round-robin pointer flips only after a single-slot grant with both clients asking.
    always_ff @(posedge clk) begin
        if (reset) r_rr <= 1'b0;
        else if (w_free == CW'(1) && wr0_valid && wr1_valid) r_rr <= ~r_rr;
    end

    // Output stage: popped entry drives the register-file port for exactly one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            RegWrite  <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
        end else begin
            RegWrite <= w_pop;
            if (w_pop) begin
                writeReg  <= w_head.addr;
                writeData <= w_head.data;
            end
        end
    end

    // Hazard: any queued entry or the live output stage targeting a nonzero source register.
    always_comb begin
        hazard_a = RegWrite && writeReg == rd_addr_a;
        hazard_b = RegWrite && writeReg == rd_addr_b;
        for (int i = 0; i < DEPTH; i++) begin
            hazard_a = hazard_a || (w_valid[i] && w_entries[i].addr == rd_addr_a);
            hazard_b = hazard_b || (w_valid[i] && w_entries[i].addr == rd_addr_b);
        end
        hazard_a = hazard_a && rd_addr_a != '0;
        hazard_b = hazard_b && rd_addr_b != '0;
    end
endmodule

// File: tb/tb_regfile_port_sched.sv
// tb_regfile_port_sched: directed and random checks against a queue-based reference model
module tb_regfile_port_sched;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr0_valid, wr1_valid;
    logic        wr0_ready, wr1_ready;
    logic [4:0]  wr0_addr, wr1_addr, rd_addr_a, rd_addr_b;
    logic [31:0] wr0_data, wr1_data;
    logic        hazard_a, hazard_b, RegWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [2:0]  occupancy;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    bit          m_rr;
    bit          m_rw;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;

    regfile_port_sched #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .wr0_valid(wr0_valid), .wr0_ready(wr0_ready), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_valid(wr1_valid), .wr1_ready(wr1_ready), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .hazard_a(hazard_a), .hazard_b(hazard_b),
        .RegWrite(RegWrite), .writeReg(writeReg), .writeData(writeData),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_haz(input logic [4:0] r);
        bit h = m_rw && m_wreg == r;
        foreach (q[i]) if (q[i].a == r) h = 1'b1;
        return h && r != 0;
    endfunction

    function automatic bit m_ready(input int c, input bit rst);
        int free = DEPTH - q.size();
        if (rst) return 1'b0;
        if (free >= 2) return 1'b1;
        if (free == 1) return (c == 1) == m_rr;
        return 1'b0;
    endfunction

    // One clock: apply inputs at negedge, check combinational outputs, clock, check registered outputs.
    task automatic cycle(input bit rst, input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                         input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                         input logic [4:0] ra, input logic [4:0] rb);
        bit r0, r1;
        int free;
        ent_t e;
        reset = rst;
        wr0_valid = v0; wr0_addr = a0; wr0_data = d0;
        wr1_valid = v1; wr1_addr = a1; wr1_data = d1;
        rd_addr_a = ra; rd_addr_b = rb;
        #1;
        r0 = m_ready(0, rst);
        r1 = m_ready(1, rst);
        free = DEPTH - q.size();
        chk("wr0_ready", {31'b0, wr0_ready}, {31'b0, r0});
        chk("wr1_ready", {31'b0, wr1_ready}, {31'b0, r1});
        chk("hazard_a", {31'b0, hazard_a}, {31'b0, m_haz(ra)});
        chk("hazard_b", {31'b0, hazard_b}, {31'b0, m_haz(rb)});
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_rr = 1'b0; m_rw = 1'b0; m_wreg = '0; m_wdata = '0;
        end else begin
            m_rw = q.size() != 0;
            if (m_rw) begin
                e = q.pop_front();
                m_wreg = e.a;
                m_wdata = e.d;
            end
            if (v0 && r0 && a0 != 0) q.push_back('{a: a0, d: d0});
            if (v1 && r1 && a1 != 0) q.push_back('{a: a1, d: d1});
            if (free == 1 && v0 && v1) m_rr = ~m_rr;
        end
        #1;
        chk("occupancy", {29'b0, occupancy}, q.size());
        chk("RegWrite", {31'b0, RegWrite}, {31'b0, m_rw});
        chk("writeReg", {27'b0, writeReg}, {27'b0, m_wreg});
        chk("writeData", writeData, m_wdata);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [4:0] ra);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, ra, 0);
    endtask

    initial begin
        reset = 1'b1;
        wr0_valid = 0; wr1_valid = 0; wr0_addr = 0; wr1_addr = 0;
        wr0_data = 0; wr1_data = 0; rd_addr_a = 0; rd_addr_b = 0;
        @(negedge clk);
        cycle(1, 1, 5, 1, 1, 6, 2, 5, 6);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_occ", {29'b0, occupancy}, 0);
        chk("reset_rw", {31'b0, RegWrite}, 0);

        // Single write with hazard tracking on source 5
        cycle(0, 1, 5, 32'h10, 0, 0, 0, 5, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 5, 0);
        chk("single_rw", {31'b0, RegWrite}, 1);
        chk("single_reg", {27'b0, writeReg}, 5);
        chk("single_data", writeData, 32'h10);
        chk("single_haz", {31'b0, hazard_a}, 1);
        idle(2, 5);

        // Dual same-address write: 0xA then 0xB
        cycle(0, 1, 3, 32'hA, 1, 3, 32'hB, 3, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 3, 0);
        chk("dual_first", writeData, 32'hA);
        cycle(0, 0, 0, 0, 0, 0, 0, 3, 0);
        chk("dual_second", writeData, 32'hB);
        idle(2, 0);

        // Contention at occupancy 3: wr0 wins first, then wr1
        cycle(0, 1, 7, 1, 1, 8, 2, 7, 8);
        cycle(0, 1, 9, 3, 1, 10, 4, 9, 10);
        chk("cont_occ", {29'b0, occupancy}, 3);
        cycle(0, 1, 11, 5, 1, 12, 6, 11, 12);
        cycle(0, 1, 13, 7, 1, 14, 8, 13, 14);
        idle(5, 0);

        // Zero register from wr1
        cycle(0, 0, 0, 0, 1, 0, 32'hFFFF, 0, 0);
        chk("zero_occ", {29'b0, occupancy}, 0);
        idle(2, 0);
        chk("zero_rw", {31'b0, RegWrite}, 0);

        // Reset pulse with entries pending
        cycle(0, 1, 1, 32'h11, 1, 2, 32'h22, 1, 2);
        cycle(0, 1, 3, 32'h33, 1, 4, 32'h44, 3, 4);
        cycle(1, 0, 0, 0, 0, 0, 0, 3, 4);
        idle(4, 3);
        chk("rst_mid_occ", {29'b0, occupancy}, 0);

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 59) == 0),
                  $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        idle(6, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
